imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the decode stage; successor to the combinational immediate extender.
- Covers all RV32I/RV64I immediate formats (I, S, B, J, U) plus the CSR zimm format.
- Offers an AUTO mode that derives the format from the opcode and flags illegal opcodes.
- Carries results through a DEPTH-stage elastic valid/ready pipeline with flush, so it can sit between fetch and execute.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64; sign extension fills to XLEN.
- DEPTH, 1, number of register stages between input and output; legal range 1..4.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  block accepts this cycle.
- in_instr  input  32  raw instruction word.
- in_imm_src  input  3  format select (imm_src_e).
- flush  input  1  synchronous pipeline kill.
- out_valid  output  1  out_imm / out_illegal valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  extended immediate.
- out_illegal  output  1  format or opcode not recognised.

Behaviour:

Clocking and reset:
- Single clock domain: clk.
- rst is synchronous and active-high.

imm_src encoding:
- 000 I: sext(instr[31:20]).
- 001 S: sext({instr[31:25], instr[11:7]}).
- 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- 011 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- 100 U: sext({instr[31:12], 12'b0}); for XLEN=64, bit 31 extends into [63:32].
- 101 Z: zext(instr[19:15]).
- 110 reserved: imm = 0, illegal = 1.
- 111 AUTO: decode by instr[6:0]:
  - 0000011 / 0010011 / 1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110111 / 0010111 → U.
  - 1110011 → Z if instr[14]=1, else I.
  - 0110011 (R-type) → imm = 0, illegal = 0.
  - Any other opcode → imm = 0, illegal = 1.

Pipeline:
- Format decode and extension are combinational ahead of stage 0. Each stage holds {valid, imm, illegal}.
- An input is accepted on in_valid && in_ready. in_ready is 0 while flush=1.
- Elastic pipeline: stage k loads from stage k-1 when stage k is empty, or when stage k transfers onward in the same cycle. in_ready = !stage0.valid || stage0 advancing.
- Output is the last stage: out_valid = last.valid. The last stage empties on out_valid && out_ready.
- Latency is exactly DEPTH cycles from acceptance to out_valid when the pipeline is empty and out_ready=1. Throughput is 1 per cycle with no bubbles when out_ready is held high.
- Backpressure: while out_ready=0, out_imm and out_illegal hold stable. Stages fill back-to-front; in_ready falls once all DEPTH stages are valid. No data is lost or reordered.
- Data registers load only on transfer; they do not toggle when a stage is idle.

Flush:
- All valid bits clear at the next edge.
- An input presented during a flush cycle is not accepted.
- Data registers keep their last value; it is don't-care because valid=0.

Reset:
- All valid bits clear; out_imm = 0; out_illegal = 0; in_ready = 1 after the reset edge.
- Reset takes priority over flush. Reset mid-stream discards all in-flight entries.
- Simultaneous out_ready and in_valid with the pipeline full: the pipeline shifts and accepts in the same cycle.

Decomposition:
- Package imm_pkg:
  - imm_src_e enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_RSV, IMM_AUTO).
  - Opcode constants (OP_LOAD, OP_OPIMM, OP_JALR, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC, OP_SYSTEM, OP_OP).
- Sub-module imm_decode, parameter XLEN: purely combinational; instr + imm_src → imm, illegal.
- imm_gen_pipe instantiates imm_decode and implements the DEPTH-stage elastic register chain.

Test Plan:
- Load, DEPTH=1, XLEN=32: lw x1,-4(x2) = 0xFFC12083 with src I, out_ready=1 → out_valid one cycle later, out_imm = 0xFFFFFFFC, illegal = 0.
- Store and branch, AUTO mode: sw x5,8(x2) = 0x00512423 → out_imm = 0x00000008. beq x0,x0,-8 = 0xFE000CE3 → out_imm = 0xFFFFFFF8.
- U-type, XLEN=64: lui x5,0x80000 = 0x800002B7 with src U → out_imm = 0xFFFFFFFF80000000.
- Backpressure, DEPTH=2: stream 4 instrs back-to-back with out_ready=0 for 3 cycles → in_ready drops after 2 accepts. All 4 emerge in order with correct values, and out_imm is stable while stalled.
- Flush and reset: with 2 entries in flight, assert flush with in_valid=1 → out_valid = 0 the next cycle and the input is not accepted. Repeat with rst → out_imm = 0, out_valid = 0.
- Illegal cases: 0x0000007F in AUTO → out_imm = 0, out_illegal = 1. src = 110 → illegal = 1. csrrwi 0x3400D073 in AUTO → out_imm = 0x00000001 (Z).

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the pipelined immediate generator.
package imm_pkg;

   typedef enum logic [2:0] {
      IMM_I    = 3'b000,
      IMM_S    = 3'b001,
      IMM_B    = 3'b010,
      IMM_J    = 3'b011,
      IMM_U    = 3'b100,
      IMM_Z    = 3'b101,
      IMM_RSV  = 3'b110,
      IMM_AUTO = 3'b111
   } imm_src_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational format resolution and immediate extension for one instruction.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  logic [2:0]      imm_src,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   imm_src_e    fmt;
   logic        r_type;
   logic [31:0] imm32;

   always_comb begin
      fmt    = imm_src_e'(imm_src);
      r_type = 1'b0;
      if (fmt == IMM_AUTO) begin
         case (instr[6:0])
            OP_LOAD, OP_OPIMM, OP_JALR: fmt = IMM_I;
            OP_STORE:                   fmt = IMM_S;
            OP_BRANCH:                  fmt = IMM_B;
            OP_JAL:                     fmt = IMM_J;
            OP_LUI, OP_AUIPC:           fmt = IMM_U;
            OP_SYSTEM:                  fmt = instr[14] ? IMM_Z : IMM_I;
            OP_OP: begin
               fmt    = IMM_RSV;
               r_type = 1'b1;
            end
            default:                    fmt = IMM_RSV;
         endcase
      end
   end

   // Every format fits a 32-bit value whose bit 31 is the sign, so XLEN
   // extension is a single signed widening at the end.
   always_comb begin
      imm32   = '0;
      illegal = 1'b0;
      case (fmt)
         IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_U: imm32 = {instr[31:12], 12'b0};
         IMM_Z: imm32 = {27'b0, instr[19:15]};
         IMM_RSV: illegal = !r_type;
         default: illegal = 1'b1;
      endcase
   end

   assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator followed by a DEPTH-stage elastic valid/ready pipeline with flush.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [2:0]      in_imm_src,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic            out_illegal
);

   logic [XLEN-1:0] dec_imm;
   logic            dec_illegal;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .instr   (in_instr),
      .imm_src (in_imm_src),
      .imm     (dec_imm),
      .illegal (dec_illegal)
   );

   logic [DEPTH-1:0]           valid_vec;
   logic [DEPTH-1:0][XLEN-1:0] imm_vec;
   logic [DEPTH-1:0]           illegal_vec;
   logic [DEPTH:0]             src_valid;
   logic [DEPTH:0]             ready;
   logic [DEPTH-1:0]           adv;
   logic [DEPTH-1:0]           load;

   // Entry k sees its upstream valid at src_valid[k]; bit 0 is the input port.
   assign src_valid = {valid_vec, in_valid};

   // ready[k]: stage k can take a new entry this cycle (empty or draining).
   always_comb begin
      ready        = '0;
      adv          = '0;
      load         = '0;
      ready[DEPTH] = out_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         adv[k]   = valid_vec[k] && ready[k+1];
         ready[k] = !valid_vec[k] || ready[k+1];
      end
      for (int k = 0; k < DEPTH; k++) begin
         load[k] = src_valid[k] && ready[k] && !flush;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic            valid_reg;
      logic [XLEN-1:0] imm_reg;
      logic            illegal_reg;
      logic [XLEN-1:0] imm_in;
      logic            illegal_in;

      if (gi == 0) begin : g_first
         assign imm_in     = dec_imm;
         assign illegal_in = dec_illegal;
      end else begin : g_rest
         assign imm_in     = imm_vec[gi-1];
         assign illegal_in = illegal_vec[gi-1];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_reg   <= 1'b0;
            imm_reg     <= '0;
            illegal_reg <= 1'b0;
         end else begin
            if (flush)
               valid_reg <= 1'b0;
            else if (load[gi])
               valid_reg <= 1'b1;
            else if (adv[gi])
               valid_reg <= 1'b0;
            if (load[gi]) begin
               imm_reg     <= imm_in;
               illegal_reg <= illegal_in;
            end
         end
      end

      assign valid_vec[gi]   = valid_reg;
      assign imm_vec[gi]     = imm_reg;
      assign illegal_vec[gi] = illegal_reg;
   end

   assign in_ready    = ready[0] && !flush;
   assign out_valid   = valid_vec[DEPTH-1];
   assign out_imm     = imm_vec[DEPTH-1];
   assign out_illegal = illegal_vec[DEPTH-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: a 32-bit single-stage and a 64-bit two-stage instance share stimulus.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [2:0]  in_imm_src;
   logic        flush;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, a_out_illegal;
   logic [31:0] a_out_imm;
   logic        b_in_ready, b_out_valid, b_out_illegal;
   logic [63:0] b_out_imm;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .DEPTH(1)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .in_imm_src(in_imm_src), .flush(flush),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .out_imm(a_out_imm), .out_illegal(a_out_illegal)
   );

   imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .in_imm_src(in_imm_src), .flush(flush),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_imm(b_out_imm), .out_illegal(b_out_illegal)
   );

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  src;
      logic [63:0] imm;
      logic        ill;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] expq[$];
      logic [63:0] front;
      int acc, rcv;

      vecs[0]  = '{32'hFFC12083, 3'b000, 64'hFFFFFFFFFFFFFFFC, 1'b0}; // lw x1,-4(x2)
      vecs[1]  = '{32'h00512423, 3'b111, 64'h0000000000000008, 1'b0}; // sw auto
      vecs[2]  = '{32'hFE000CE3, 3'b111, 64'hFFFFFFFFFFFFFFF8, 1'b0}; // beq auto
      vecs[3]  = '{32'h800002B7, 3'b100, 64'hFFFFFFFF80000000, 1'b0}; // lui 0x80000
      vecs[4]  = '{32'h0000007F, 3'b111, 64'h0000000000000000, 1'b1}; // bad opcode
      vecs[5]  = '{32'hFFC12083, 3'b110, 64'h0000000000000000, 1'b1}; // reserved src
      vecs[6]  = '{32'h3400D073, 3'b111, 64'h0000000000000001, 1'b0}; // csrrwi auto
      vecs[7]  = '{32'hFFDFF06F, 3'b111, 64'hFFFFFFFFFFFFFFFC, 1'b0}; // jal x0,-4
      vecs[8]  = '{32'h000F8000, 3'b101, 64'h000000000000001F, 1'b0}; // explicit Z
      vecs[9]  = '{32'h002081B3, 3'b111, 64'h0000000000000000, 1'b0}; // add (R-type)
      vecs[10] = '{32'h7FF00093, 3'b111, 64'h00000000000007FF, 1'b0}; // addi max
      vecs[11] = '{32'hFE512FA3, 3'b001, 64'hFFFFFFFFFFFFFFFF, 1'b0}; // sw -1 explicit
      vecs[12] = '{32'h30001073, 3'b111, 64'h0000000000000300, 1'b0}; // csrrw -> I
      vecs[13] = '{32'h12345097, 3'b111, 64'h0000000012345000, 1'b0}; // auipc
      vecs[14] = '{32'h80008067, 3'b111, 64'hFFFFFFFFFFFFF800, 1'b0}; // jalr -2048
      vecs[15] = '{32'h7FFFF0B7, 3'b100, 64'h000000007FFFF000, 1'b0}; // lui positive

      rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_imm_src = '0;
      flush = 1'b0; out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_a_valid", 64'(a_out_valid), 64'd0);
      chk("rst_a_imm",   64'(a_out_imm),   64'd0);
      chk("rst_a_ready", 64'(a_in_ready),  64'd1);
      chk("rst_b_valid", 64'(b_out_valid), 64'd0);
      chk("rst_b_imm",   b_out_imm,        64'd0);
      chk("rst_b_ill",   64'(b_out_illegal), 64'd0);
      chk("rst_b_ready", 64'(b_in_ready),  64'd1);

      // Single-shot vectors: DEPTH=1 answers after one edge, DEPTH=2 after two.
      for (int i = 0; i < 16; i++) begin
         in_instr = vecs[i].instr; in_imm_src = vecs[i].src;
         in_valid = 1'b1; out_ready = 1'b1;
         tick();
         in_valid = 1'b0;
         chk($sformatf("v%0d_a_valid", i), 64'(a_out_valid), 64'd1);
         chk($sformatf("v%0d_a_imm", i),   64'(a_out_imm),   64'(vecs[i].imm[31:0]));
         chk($sformatf("v%0d_a_ill", i),   64'(a_out_illegal), 64'(vecs[i].ill));
         chk($sformatf("v%0d_b_early", i), 64'(b_out_valid), 64'd0);
         tick();
         chk($sformatf("v%0d_b_valid", i), 64'(b_out_valid), 64'd1);
         chk($sformatf("v%0d_b_imm", i),   b_out_imm,        vecs[i].imm);
         chk($sformatf("v%0d_b_ill", i),   64'(b_out_illegal), 64'(vecs[i].ill));
         chk($sformatf("v%0d_a_drain", i), 64'(a_out_valid), 64'd0);
         $display("vec %0d instr=%h src=%0d exp_imm=%h exp_ill=%0d b_imm=%h",
                  i, vecs[i].instr, vecs[i].src, vecs[i].imm, vecs[i].ill, b_out_imm);
      end
      tick();

      // Back-to-back stream into the two-stage instance: one result per cycle.
      in_imm_src = 3'b000; out_ready = 1'b1;
      for (int cyc = 0; cyc < 5; cyc++) begin
         in_valid = (cyc < 3);
         in_instr = {12'(16 + cyc), 20'h00013};
         #1;
         if (cyc >= 2) begin
            chk($sformatf("tp_valid_c%0d", cyc), 64'(b_out_valid), 64'd1);
            chk($sformatf("tp_imm_c%0d", cyc),   b_out_imm, 64'(16 + cyc - 2));
         end
         tick();
      end
      $display("throughput stream of 3 done");
      in_valid = 1'b0;
      tick(); tick();

      // Backpressure: 4 entries, downstream stalled for the first 3 cycles.
      acc = 0; rcv = 0;
      for (int cyc = 0; cyc < 30 && rcv < 4; cyc++) begin
         in_valid   = (acc < 4);
         in_instr   = {12'(acc + 1), 20'h00013};
         in_imm_src = 3'b000;
         out_ready  = (cyc >= 3);
         #1;
         if (cyc < 3)
            chk($sformatf("bp_in_ready_c%0d", cyc), 64'(b_in_ready), 64'(cyc != 2));
         front = (expq.size() > 0) ? expq[0] : 64'hDEAD_DEAD_DEAD_DEAD;
         if (b_out_valid && out_ready) begin
            chk($sformatf("bp_order_%0d", rcv), b_out_imm, front);
            $display("bp out %0d imm=%h", rcv, b_out_imm);
            if (expq.size() > 0) void'(expq.pop_front());
            rcv++;
         end else if (b_out_valid) begin
            chk($sformatf("bp_stall_c%0d", cyc), b_out_imm, front);
         end
         if (in_valid && b_in_ready) begin
            expq.push_back(64'(acc + 1));
            acc++;
         end
         tick();
      end
      chk("bp_count", 64'(rcv), 64'd4);
      in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick();

      // Flush with two entries in flight and an input offered during the flush.
      out_ready = 1'b0; in_valid = 1'b1; in_imm_src = 3'b000;
      in_instr = {12'd5, 20'h00013}; tick();
      in_instr = {12'd6, 20'h00013}; tick();
      flush = 1'b1; in_instr = {12'd7, 20'h00013};
      #1;
      chk("fl_in_ready", 64'(b_in_ready), 64'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("fl_valid_0", 64'(b_out_valid), 64'd0);
      chk("fl_a_valid", 64'(a_out_valid), 64'd0);
      tick();
      chk("fl_valid_1", 64'(b_out_valid), 64'd0);
      tick();
      chk("fl_valid_2", 64'(b_out_valid), 64'd0);
      $display("flush sequence done");

      // Reset mid-stream, with an illegal entry among those in flight.
      out_ready = 1'b0; in_valid = 1'b1;
      in_instr = 32'h0000007F; in_imm_src = 3'b111; tick();
      in_instr = {12'd10, 20'h00013}; in_imm_src = 3'b000; tick();
      chk("rs_pre_full", 64'(b_in_ready), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("rs_b_valid", 64'(b_out_valid), 64'd0);
      chk("rs_b_imm",   b_out_imm,        64'd0);
      chk("rs_b_ill",   64'(b_out_illegal), 64'd0);
      chk("rs_b_ready", 64'(b_in_ready),  64'd1);
      chk("rs_a_valid", 64'(a_out_valid), 64'd0);
      chk("rs_a_imm",   64'(a_out_imm),   64'd0);
      out_ready = 1'b1;
      tick(); tick();
      chk("rs_b_after", 64'(b_out_valid), 64'd0);
      $display("reset sequence done");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
